fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port `stall`, input, 1 bit: hazard hold request from decode.
REQ-004 SHALL have port `PcSel`, input, 1 bit: taken branch/jump from control.
REQ-005 SHALL have port `BrTarget`, input, 16 bits: redirect address.
REQ-006 SHALL have port `Halt`, input, 1 bit: HALT decoded by control for the instruction in IF/ID.
REQ-007 SHALL have port `imem_addr`, output, 16 bits: fetch address, equal to the current PC.
REQ-008 SHALL have port `imem_data`, input, 16 bits: instruction word.
REQ-009 SHALL have port `imem_rdy`, input, 1 bit: `imem_data` valid this cycle.
REQ-010 SHALL have port `IfId_Instr`, output, 16 bits: registered instruction; bits [15:11] feed control `Instr`.
REQ-011 SHALL have port `IfId_PcPlus2`, output, 16 bits: registered PC+2 of that instruction.
REQ-012 SHALL have port `IfId_Valid`, output, 1 bit: IF/ID holds a real instruction.
REQ-013 SHALL have port `Halted`, output, 1 bit: processor stopped.
REQ-014 SHALL have port `Err`, output, 1 bit: sticky misaligned-redirect flag (see Configuration).

Function
REQ-015 SHALL implement FSM states RUN, MISS, HALTED.
REQ-016 SHALL apply per-cycle priority in this order: `rst` > `Halt` > `PcSel` > `stall` > `imem_rdy`=0 > normal fetch.
REQ-017 SHALL act on `Halt` only when `IfId_Valid`=1; then next state HALTED, PC holds, IF/ID <= NOP with Valid=0, and `Halted`=1 from the next cycle.
REQ-018 SHALL leave HALTED only on `rst`; all other inputs are ignored in HALTED.
REQ-019 On `PcSel`=1 in RUN or MISS, SHALL set PC <= `BrTarget`, IF/ID <= NOP with Valid=0, next state RUN; `stall` is overridden.
REQ-020 On `stall`=1 (with `PcSel`=0), SHALL hold PC, IF/ID and state unchanged.
REQ-021 In RUN with `imem_rdy`=0, SHALL hold PC, set IF/ID <= NOP with Valid=0, and go to MISS.
REQ-022 In MISS, SHALL hold PC and insert NOPs until `imem_rdy`=1, then perform a normal fetch and return to RUN.
REQ-023 A normal fetch SHALL do: PC <= PC+2 (mod 2^16, 0xFFFE wraps to 0x0000), `IfId_Instr` <= `imem_data`, `IfId_PcPlus2` <= PC+2, `IfId_Valid` <= 1.
REQ-024 SHALL give one-cycle latency from the `imem_addr` presentation edge to `IfId_Instr`; throughput SHALL be one instruction per cycle with no stalls.
REQ-025 The NOP encoding SHALL be 16'h0800 (opcode 00001).
REQ-026 `imem_addr` SHALL be combinational from the PC register.

Reset
REQ-027 On `rst`=1 at a clock edge, SHALL set: PC=0x0000, state RUN, `IfId_Instr`=16'h0800, `IfId_PcPlus2`=0, `IfId_Valid`=0, `Halted`=0, `Err`=0.
REQ-028 Reset asserted mid-MISS or in HALTED SHALL produce the REQ-027 values; no pending redirect or halt survives.

Configuration
REQ-029 Macro `FETCH_ALIGN_CHK_EN` defined: a redirect with `BrTarget[0]`=1 SHALL set `Err`=1 (sticky until `rst`), SHALL behave as a halt (state HALTED), and PC SHALL hold.
REQ-030 Macro `FETCH_ALIGN_CHK_EN` undefined: `Err` SHALL be tied to 0, and a redirect SHALL load PC <= `BrTarget` & 16'hFFFE.

Structure
REQ-031 Shared package `fetch_pkg` SHALL hold: state encoding (RUN/MISS/HALTED), NOP_INSTR=16'h0800, RESET_PC=16'h0000.
REQ-032 The PC SHALL use one sub-module, `pc_reg`: 16-bit register with synchronous reset value, write enable, and data input.

Verification
REQ-033 Reset, then `imem_rdy`=1 with data 0x4000, 0x4001, 0x4002: `IfId_Instr` sequence 0x4000/0x4001/0x4002 with `IfId_PcPlus2` 0x0002/0x0004/0x0006, Valid=1 each cycle.
REQ-034 PC=0x0010 with `PcSel`=1 and `BrTarget`=0x0100 asserted together with `stall`=1: next PC=0x0100, IF/ID=0x0800 with Valid=0.
REQ-035 `imem_rdy`=0 for 3 cycles at PC=0x0020: PC holds 0x0020, 3 bubbles, state MISS; `imem_rdy`=1 -> fetch at 0x0020, PC=0x0022, state RUN.
REQ-036 `Halt`=1 with Valid=1: `Halted`=1 next cycle and PC frozen for 10 cycles despite `PcSel`=1; `rst` -> PC=0x0000, `Halted`=0.
REQ-037 PC=0xFFFE, normal fetch: next PC=0x0000 and `IfId_PcPlus2`=0x0000.
REQ-038 `BrTarget`=0x0101 with `PcSel`=1: with `FETCH_ALIGN_CHK_EN`, `Err`=1 and state HALTED; without it, PC=0x0100 and `Err`=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared fetch-stage types and constants (state encoding, NOP, reset PC).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MISS   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [15:0] RESET_PC  = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module  : pc_reg
// Brief   : 16-bit program counter register with sync reset value and write enable.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction fetch stage with IF/ID register, miss/halt handling.
//           Optional misaligned-redirect trap: FETCH_ALIGN_CHK_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        PcSel,
    input  logic [15:0] BrTarget,
    input  logic        Halt,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_rdy,
    output logic [15:0] IfId_Instr,
    output logic [15:0] IfId_PcPlus2,
    output logic        IfId_Valid,
    output logic        Halted,
    output logic        Err
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [15:0]  w_pc;
    logic [15:0]  w_pc_plus2;
    logic         w_pc_we;
    logic [15:0]  w_pc_d;
    logic [15:0]  w_instr_d;
    logic [15:0]  w_pp2_d;
    logic         w_valid_d;
`ifdef FETCH_ALIGN_CHK_EN
    logic         w_err_set;
    logic         r_err;
`endif

    pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .i_we (w_pc_we),
        .i_d  (w_pc_d),
        .o_q  (w_pc)
    );

    assign imem_addr  = w_pc;
    assign w_pc_plus2 = w_pc + 16'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            IfId_Instr   <= NOP_INSTR;
            IfId_PcPlus2 <= 16'h0000;
            IfId_Valid   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            IfId_Instr   <= w_instr_d;
            IfId_PcPlus2 <= w_pp2_d;
            IfId_Valid   <= w_valid_d;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_we     = 1'b0;
        w_pc_d      = w_pc;
        w_instr_d   = IfId_Instr;
        w_pp2_d     = IfId_PcPlus2;
        w_valid_d   = IfId_Valid;
`ifdef FETCH_ALIGN_CHK_EN
        w_err_set   = 1'b0;
`endif
        case (r_state)
            ST_HALTED: begin
                // Frozen until reset.
            end
            default: begin
                if (Halt && IfId_Valid) begin
                    w_state_nxt = ST_HALTED;
                    w_instr_d   = NOP_INSTR;
                    w_valid_d   = 1'b0;
                end else if (PcSel) begin
                    w_instr_d = NOP_INSTR;
                    w_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                    if (BrTarget[0]) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_HALTED;
                    end else
`endif
                    begin
                        w_pc_we     = 1'b1;
                        w_pc_d      = BrTarget & 16'hFFFE;
                        w_state_nxt = ST_RUN;
                    end
                end else if (stall) begin
                    // Hold everything for decode.
                end else if (!imem_rdy) begin
                    w_state_nxt = ST_MISS;
                    w_instr_d   = NOP_INSTR;
                    w_valid_d   = 1'b0;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_pc_we     = 1'b1;
                    w_pc_d      = w_pc_plus2;
                    w_instr_d   = imem_data;
                    w_pp2_d     = w_pc_plus2;
                    w_valid_d   = 1'b1;
                end
            end
        endcase
    end

    assign Halted = (r_state == ST_HALTED);

`ifdef FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end
    assign Err = r_err;
`else
    assign Err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Directed plus randomized bench for fetch_stage against a behavioural model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        PcSel;
    logic [15:0] BrTarget;
    logic        Halt;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_rdy;
    logic [15:0] IfId_Instr;
    logic [15:0] IfId_PcPlus2;
    logic        IfId_Valid;
    logic        Halted;
    logic        Err;

    int n_total = 0;
    int n_bad   = 0;

    // Architectural view of the stage: RUN and MISS are indistinguishable here.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pp2;
    logic        m_valid;
    logic        m_halted;
    logic        m_err;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .PcSel        (PcSel),
        .BrTarget     (BrTarget),
        .Halt         (Halt),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .imem_rdy     (imem_rdy),
        .IfId_Instr   (IfId_Instr),
        .IfId_PcPlus2 (IfId_PcPlus2),
        .IfId_Valid   (IfId_Valid),
        .Halted       (Halted),
        .Err          (Err)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_pc = 16'h0000; m_instr = 16'h0800; m_pp2 = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;
        end else if (m_halted) begin
        end else if (Halt && m_valid) begin
            m_halted = 1'b1; m_instr = 16'h0800; m_valid = 1'b0;
        end else if (PcSel) begin
            m_instr = 16'h0800; m_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            if (BrTarget[0]) begin
                m_err = 1'b1; m_halted = 1'b1;
            end else
`endif
                m_pc = {BrTarget[15:1], 1'b0};
        end else if (stall) begin
        end else if (!imem_rdy) begin
            m_instr = 16'h0800; m_valid = 1'b0;
        end else begin
            m_instr = imem_data;
            m_pp2   = 16'((32'(m_pc) + 2) % 65536);
            m_pc    = m_pp2;
            m_valid = 1'b1;
        end
    endtask

    task automatic cyc(input logic r, input logic st, input logic ps, input logic [15:0] bt,
                       input logic h, input logic rdy, input logic [15:0] d);
        rst = r; stall = st; PcSel = ps; BrTarget = bt; Halt = h; imem_rdy = rdy; imem_data = d;
        @(posedge clk);
        model_step();
        #1;
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("valid", {15'd0, IfId_Valid}, {15'd0, m_valid});
        check_eq("instr", IfId_Instr, m_instr);
        if (m_valid) check_eq("pcplus2", IfId_PcPlus2, m_pp2);
        check_eq("halted", {15'd0, Halted}, {15'd0, m_halted});
        check_eq("err", {15'd0, Err}, {15'd0, m_err});
    endtask

    logic [15:0] frozen_pc;

    initial begin
        rst = 1'b1; stall = 1'b0; PcSel = 1'b0; BrTarget = 16'h0; Halt = 1'b0;
        imem_rdy = 1'b0; imem_data = 16'h0;
        m_pc = 16'hxxxx; m_instr = 16'hxxxx; m_pp2 = 16'hxxxx;
        m_valid = 1'bx; m_halted = 1'bx; m_err = 1'bx;
        #2;

        // Reset values
        cyc(1, 0, 0, 16'h0, 0, 0, 16'h0);
        check_eq("rst_pc", imem_addr, 16'h0000);
        check_eq("rst_instr", IfId_Instr, 16'h0800);
        check_eq("rst_pp2", IfId_PcPlus2, 16'h0000);
        check_eq("rst_valid", {15'd0, IfId_Valid}, 16'h0000);

        // Straight-line fetch
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 16'h0, 0, 1, 16'h4000 + 16'(i));
            check_eq("seq_instr", IfId_Instr, 16'h4000 + 16'(i));
            check_eq("seq_pp2", IfId_PcPlus2, 16'(2 * (i + 1)));
            check_eq("seq_valid", {15'd0, IfId_Valid}, 16'h0001);
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 16'h0, 0, 1, 16'h1000 + 16'(i));
        check_eq("pc_at_10", imem_addr, 16'h0010);

        // Redirect overrides stall
        cyc(0, 1, 1, 16'h0100, 0, 1, 16'hABCD);
        check_eq("redir_pc", imem_addr, 16'h0100);
        check_eq("redir_instr", IfId_Instr, 16'h0800);
        check_eq("redir_valid", {15'd0, IfId_Valid}, 16'h0000);

        // Memory miss for three cycles
        cyc(0, 0, 1, 16'h0020, 0, 1, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 16'h0, 0, 0, 16'hDEAD);
            check_eq("miss_pc", imem_addr, 16'h0020);
            check_eq("miss_bubble", IfId_Instr, 16'h0800);
        end
        cyc(0, 0, 0, 16'h0, 0, 1, 16'h1234);
        check_eq("miss_end_instr", IfId_Instr, 16'h1234);
        check_eq("miss_end_pc", imem_addr, 16'h0022);

        // PC wrap
        cyc(0, 0, 1, 16'hFFFE, 0, 1, 16'h0);
        cyc(0, 0, 0, 16'h0, 0, 1, 16'h5555);
        check_eq("wrap_pc", imem_addr, 16'h0000);
        check_eq("wrap_pp2", IfId_PcPlus2, 16'h0000);

        // Odd redirect target
        cyc(0, 0, 1, 16'h0101, 0, 1, 16'h0);
`ifdef FETCH_ALIGN_CHK_EN
        check_eq("odd_err", {15'd0, Err}, 16'h0001);
        check_eq("odd_halted", {15'd0, Halted}, 16'h0001);
`else
        check_eq("odd_pc", imem_addr, 16'h0100);
        check_eq("odd_err", {15'd0, Err}, 16'h0000);
`endif

        // Halt freezes the stage until reset
        cyc(1, 0, 0, 16'h0, 0, 1, 16'h0);
        cyc(0, 0, 0, 16'h0, 0, 1, 16'h7777);
        cyc(0, 0, 1, 16'h0300, 1, 1, 16'h7778);
        check_eq("halt_set", {15'd0, Halted}, 16'h0001);
        frozen_pc = imem_addr;
        check_eq("halt_pc", frozen_pc, 16'h0002);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 16'($urandom), 1'($urandom), 1, 16'($urandom));
            check_eq("halt_frozen", imem_addr, 16'h0002);
        end
        cyc(1, 0, 1, 16'h0300, 0, 1, 16'h0);
        check_eq("halt_rst_pc", imem_addr, 16'h0000);
        check_eq("halt_rst_flag", {15'd0, Halted}, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] bt;
            bt = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 9) == 0),
                bt,
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 4) != 0),
                16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
